// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler
//   Shares one SPI DAC driver among NUM_REQ requesters with round-robin
//   arbitration. A grant issues a one-cycle start to the driver and holds
//   the selected code until the driver reports done. A minimum idle gap
//   follows each update. A watchdog aborts an update that never completes
//   and raises a sticky error.
//
// Handshake: a requester holds req_valid high and req_data stable until it
//   sees its req_ready bit. req_ready is a one-cycle, one-hot strobe that
//   coincides with dac_start. A requester whose valid was low in the
//   arbitration cycle is never granted.
//
// Ports:
//   clk, reset   system clock; asynchronous active-high reset
//   req_valid    per-requester request valid
//   req_data     requester i code at [i*DATA_W +: DATA_W]
//   req_ready    one-hot acceptance strobe (registered)
//   dac_start    one-cycle start pulse to the DAC driver (registered)
//   dac_data     code presented to the DAC driver (registered, held)
//   dac_done     done pulse from the driver, only honoured in WAIT_DONE
//   grant_id     index of the requester currently or last served
//   busy         high whenever the FSM is not in IDLE
//   timeout_err  sticky watchdog error; err_clear clears it, set wins
//   err_clear    synchronous clear of timeout_err
//   state_dbg    current FSM state (IDLE=0, ISSUE=1, WAIT_DONE=2, GAP=3)
module dac_update_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 16,
  parameter int MIN_GAP = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dac_start,
  output logic [DATA_W-1:0]         dac_data,
  input  logic                      dac_done,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clear,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  // With no gap configured the update ends straight back in IDLE.
  localparam state_t AFTER_WAIT = (MIN_GAP == 0) ? IDLE : GAP;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]  req_ready_d;
  logic                dac_start_d;
  logic [DATA_W-1:0]   dac_data_d;
  logic [ID_W-1:0]     grant_id_d;
  logic                busy_d;
  logic                timeout_err_d;
  logic                set_err;

  // Round-robin search: the lowest valid index at or above ptr wins;
  // failing that, the lowest valid index below ptr. Scanning downward lets
  // the last hit in each half be the lowest one.
  logic                hi_found;
  logic [ID_W-1:0]     hi_id, lo_id, win_id;
  logic [DATA_W-1:0]   hi_data, lo_data, win_data;

  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    hi_data  = '0;
    lo_data  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
          hi_data  = req_data[i*DATA_W +: DATA_W];
        end else begin
          lo_id   = ID_W'(i);
          lo_data = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
    win_id   = hi_found ? hi_id   : lo_id;
    win_data = hi_found ? hi_data : lo_data;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wd_cnt_d    = wd_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    req_ready_d = '0;
    dac_start_d = 1'b0;
    dac_data_d  = dac_data;
    grant_id_d  = grant_id;
    set_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          dac_data_d  = win_data;
          grant_id_d  = win_id;
          req_ready_d = NUM_REQ'(1) << win_id;
          dac_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        wd_cnt_d = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done is checked first so it wins over a coincident timeout
        if (dac_done) begin
          gap_cnt_d = '0;
          state_d   = AFTER_WAIT;
        end else if (wd_cnt_q == WD_LAST) begin
          set_err   = 1'b1;
          gap_cnt_d = '0;
          state_d   = AFTER_WAIT;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d        = (state_d != IDLE);
    timeout_err_d = set_err | (timeout_err & ~err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wd_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      req_ready   <= '0;
      dac_start   <= 1'b0;
      dac_data    <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wd_cnt_q    <= wd_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      req_ready   <= req_ready_d;
      dac_start   <= dac_start_d;
      dac_data    <= dac_data_d;
      grant_id    <= grant_id_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler. The reference model works on whole
// updates: requester queues, a round-robin pointer, and the cycle numbers
// at which each update starts, finishes and frees the scheduler again.
// Every cycle all registered outputs are compared with the model.
module tb_dac_update_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 16;
  localparam int MIN_GAP = 8;
  localparam int TIMEOUT = 64;
  localparam int BIG     = 32'h7fffffff;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      dac_start;
  logic [DATA_W-1:0]         dac_data;
  logic                      dac_done = 1'b0;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      timeout_err;
  logic                      err_clear = 1'b0;
  logic [1:0]                state_dbg;

  dac_update_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W),
    .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dac_start(dac_start), .dac_data(dac_data), .dac_done(dac_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
    .err_clear(err_clear), .state_dbg(state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [DATA_W-1:0] rq_q [NUM_REQ][$];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_id_q[$];
  int                c = 0;
  int                free_at, start_at, last_start, wait_hi, done_at, err_at, clr_at;
  int                ptr_m, cur_id;
  logic [DATA_W-1:0] cur_data;
  logic              err_m;
  int                lat_fix = 20;
  bit                lat_rand = 0;
  bit                noise = 0;
  bit                clr_with_to = 0;

  function automatic int rr_pick(input int p, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return 0;
  endfunction

  function automatic bit model_idle();
    for (int i = 0; i < NUM_REQ; i++)
      if (rq_q[i].size() != 0) return 0;
    return (c >= free_at);
  endfunction

  task automatic model_init();
    cur_id = 0; cur_data = '0; err_m = 1'b0; ptr_m = 0;
    free_at = 0; start_at = -1; last_start = -1; wait_hi = -1;
    done_at = -1; err_at = -1; clr_at = -1;
  endtask

  // One clock cycle: check outputs of cycle c, then drive inputs for the
  // edge that ends cycle c and advance the model.
  task automatic step();
    logic [NUM_REQ-1:0]        v;
    logic [NUM_REQ*DATA_W-1:0] d;
    int  lat;
    int  w;
    bit  clr;
    bit  in_wait;
    @(negedge clk);
    c++;
    if (c == start_at) begin
      cur_data = exp_q.pop_front();
      cur_id   = exp_id_q.pop_front();
      void'(rq_q[cur_id].pop_front());
      if (lat_rand) lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      else          lat = lat_fix;
      if (lat == 0) begin
        // driver never answers: watchdog aborts after TIMEOUT wait cycles
        done_at = -1;
        wait_hi = c + TIMEOUT;
        err_at  = c + TIMEOUT + 1;
        free_at = c + TIMEOUT + MIN_GAP + 1;
      end else begin
        done_at = c + lat;
        wait_hi = c + lat;
        free_at = c + lat + MIN_GAP + 1;
      end
      last_start = c;
      if (clr_with_to) clr_at = c + TIMEOUT;
    end

    check_eq("dac_start", 32'(dac_start), 32'(c == start_at));
    check_eq("req_ready", 32'(req_ready), (c == start_at) ? (32'd1 << cur_id) : 32'd0);
    check_eq("grant_id", 32'(grant_id), 32'(cur_id));
    check_eq("dac_data", 32'(dac_data), 32'(cur_data));
    check_eq("busy", 32'(busy), 32'(last_start >= 0 && c >= last_start && c < free_at));
    check_eq("timeout_err", 32'(timeout_err), 32'(err_m));

    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (rq_q[i].size() != 0);
      d[i*DATA_W +: DATA_W] = v[i] ? rq_q[i][0] : DATA_W'($urandom);
    end
    req_valid = v;
    req_data  = d;
    in_wait   = (last_start >= 0 && c > last_start && c <= wait_hi);
    dac_done  = (c == done_at) || (noise && !in_wait && $urandom_range(0, 7) == 0);
    clr       = (c == clr_at) || (noise && $urandom_range(0, 19) == 0);
    err_clear = clr;

    if (c >= free_at && v != '0) begin
      w = rr_pick(ptr_m, v);
      exp_q.push_back(rq_q[w][0]);
      exp_id_q.push_back(w);
      ptr_m    = (w + 1) % NUM_REQ;
      start_at = c + 1;
      free_at  = BIG;
    end
    err_m = (c + 1 == err_at) ? 1'b1 : (clr ? 1'b0 : err_m);
  endtask

  task automatic run_until_idle();
    int n = 0;
    do begin
      step();
      n++;
    end while (!model_idle() && n < 3000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_dac_start"}, 32'(dac_start), 32'd0);
    check_eq({tag, "_dac_data"}, 32'(dac_data), 32'd0);
    check_eq({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    req_valid = '0; dac_done = 1'b0; err_clear = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq_q[i].delete();
    exp_q.delete();
    exp_id_q.delete();
    repeat (2) begin
      @(negedge clk);
      c++;
    end
    reset = 1'b0;
    model_init();
  endtask

  initial begin
    int pre;
    int n;
    model_init();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // contention: all four valid, two rounds
    for (int r = 0; r < 2; r++) begin
      rq_q[0].push_back(16'h1111); rq_q[1].push_back(16'h2222);
      rq_q[2].push_back(16'h3333); rq_q[3].push_back(16'h4444);
      lat_fix = 12;
      run_until_idle();
    end

    // single request with a 20-cycle driver
    lat_fix = 20;
    rq_q[0].push_back(16'hA5C3);
    run_until_idle();

    // pointer rotation: 2 alone, then 0 and 3 together
    lat_fix = 5;
    rq_q[2].push_back(16'h0222);
    run_until_idle();
    rq_q[0].push_back(16'h0C00); rq_q[3].push_back(16'h0C33);
    run_until_idle();

    // timeout, clear, next request still served
    lat_fix = 0;
    rq_q[1].push_back(16'hDEAD);
    run_until_idle();
    clr_at = c + 1;
    repeat (3) step();
    lat_fix = 7;
    rq_q[3].push_back(16'hBEEF);
    run_until_idle();

    // clear coinciding with a new timeout: set wins
    lat_fix = 0; clr_with_to = 1;
    rq_q[2].push_back(16'h7777);
    run_until_idle();
    clr_with_to = 0; clr_at = -1;
    repeat (2) step();
    clr_at = c + 1;
    repeat (3) step();

    // done on the final watchdog cycle: no error
    lat_fix = TIMEOUT;
    rq_q[0].push_back(16'h5A5A);
    run_until_idle();
    repeat (2) step();

    // reset during WAIT_DONE of a requester-1 grant, then 1 and 2 together
    lat_fix = 30;
    pre = last_start;
    rq_q[1].push_back(16'h1BAD);
    n = 0;
    while (!(last_start != pre && c == last_start + 5) && n < 200) begin
      step();
      n++;
    end
    mid_reset();
    lat_fix = 5;
    rq_q[1].push_back(16'h0111); rq_q[2].push_back(16'h0222);
    run_until_idle();

    // randomized traffic with random latencies, spurious done and clears
    noise = 1; lat_rand = 1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        int r;
        r = int'($urandom_range(0, NUM_REQ - 1));
        if (rq_q[r].size() < 3) rq_q[r].push_back(DATA_W'($urandom));
      end
      step();
    end
    noise = 0; lat_rand = 0; lat_fix = 10;
    run_until_idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_update_scheduler.md
Name: dac_update_scheduler

Overview:
- Shares one PmodDA3 SPI DAC driver among NUM_REQ independent requesters using round-robin arbitration.
- Each requester offers a 16-bit DAC code through a valid/ready handshake.
- The block issues a single-cycle start to the driver, holds the code stable until the driver's done pulse, then enforces a minimum idle gap before the next update.
- A watchdog flags a sticky error if the driver never returns done.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ
DATA_W, 16, DAC code width
MIN_GAP, 8, clk cycles spent in GAP after each completed or aborted update (0 = no gap)
TIMEOUT, 64, max clk cycles in WAIT_DONE before abort (>= 20)

Ports:
clk  input  1  system clock (50 MHz), same clock as the DAC driver
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_data  input  NUM_REQ*DATA_W  requester i code at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot acceptance strobe
dac_start  output  1  start pulse to DAC driver
dac_data  output  DATA_W  code to DAC driver
dac_done  input  1  done pulse from DAC driver
grant_id  output  ID_W  index of the requester currently or last served
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky watchdog error
err_clear  input  1  synchronous clear of timeout_err

Behaviour:
- Reset: clk and reset as already decided (reset asynchronous, active-high; clock clk).
- Reset values: state=IDLE, req_ready=0, dac_start=0, dac_data=0, grant_id=0, busy=0, timeout_err=0, rr pointer=0 (requester 0 has top priority first), all counters=0.
- States: IDLE, ISSUE, WAIT_DONE, GAP. All outputs are registered.
- IDLE:
  - If any req_valid bit is set, select the winner by searching from index ptr, ptr+1, ... modulo NUM_REQ; first set bit wins.
  - Register dac_data <= winner's req_data and grant_id <= winner; go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready[grant_id]=1 and dac_start=1 this cycle only.
  - ptr <= (grant_id+1) mod NUM_REQ; go to WAIT_DONE with watchdog counter cleared.
- WAIT_DONE:
  - dac_data is held constant; the driver samples it one cycle after start.
  - Watchdog counter increments each cycle.
  - On dac_done=1, go to GAP.
  - Else, when counter reaches TIMEOUT-1, set timeout_err=1 and go to GAP.
  - If dac_done and the timeout condition occur in the same cycle, done wins and timeout_err is not set.
- GAP:
  - Counts MIN_GAP cycles, then goes to IDLE.
  - If MIN_GAP=0, WAIT_DONE exits directly to IDLE.
- Latency: request valid in IDLE at cycle N -> req_ready/dac_start at N+1. For continuously pending requests, the update period is 2 + driver latency + MIN_GAP cycles.
- Handshake rules:
  - Requesters keep req_valid high and req_data stable until they see req_ready.
  - Dropping req_valid early is a protocol violation; the granted code is still issued.
  - req_ready is never asserted for a requester whose valid was low at the arbitration cycle.
- dac_done outside WAIT_DONE is ignored.
- timeout_err:
  - Sticky; cleared by err_clear=1 on a clock edge.
  - Set wins over clear in the same cycle.
  - Does not block further arbitration.
- Reset mid-operation (any state) returns everything to reset values immediately; the interrupted update is not retried.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 grants.

Test Plan:
- Single request: req_valid=0001, data0=16'hA5C3; driver model returns done 20 cycles after start -> one dac_start pulse, dac_data=A5C3 held through done, req_ready=0001 for one cycle, grant_id=0, busy falls after 8 GAP cycles.
- Contention: all four valid with codes 1111/2222/3333/4444 -> starts in order 0,1,2,3 with matching dac_data; a second round after re-asserting valid continues 0,1,2,3.
- Pointer rotation: grant 2 alone, then raise 0 and 3 together -> grant 3 first, then 0.
- Timeout: driver model never returns done -> timeout_err=1 exactly TIMEOUT cycles after ISSUE; next request is still served. err_clear together with a new timeout -> err stays 1.
- Boundary: dac_done arrives on the timeout cycle -> timeout_err stays 0.
- Reset asserted during WAIT_DONE -> all outputs 0 asynchronously; after release, a new request from requester 1 is granted as the first grant (ptr=0 search).
